// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int INS_W        = 16;
    localparam int EXT_BIT_DFLT = 15;

    typedef enum logic [2:0] {
        FETCH_INS,
        WAIT_INS,
        FETCH_EXT,
        WAIT_EXT,
        ISSUE,
        EXEC
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch unit: owns the PC, reads one or two words from a 1-cycle
// synchronous program memory, issues them to decode and waits for retire.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FETCH_INS | read first word at pc (held off while halt is high)
// WAIT_INS  | capture first word and ins_pc; pick 1- or 2-word path
// FETCH_EXT | read extension word at pc+1
// WAIT_EXT  | capture extension word
// ISSUE     | ins_en strobe; retire may already be accepted here
// EXEC      | hold instruction until retire, then update pc
module fetch
    import fetch_pkg::*;
#(
    parameter logic [INS_W-1:0] RESET_PC = 16'h0000,
    parameter int               EXT_BIT  = EXT_BIT_DFLT
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             halt,
    output logic             mem_rd,
    output logic [INS_W-1:0] mem_addr,
    input  logic [INS_W-1:0] mem_data,
    output logic [INS_W-1:0] ins,
    output logic [INS_W-1:0] ext,
    output logic             ins_en,
    output logic [INS_W-1:0] ins_pc,
    input  logic             retire,
    input  logic             set_pc,
    input  logic             add_pc,
    input  logic             inc_pc,
    input  logic [INS_W-1:0] pc_arg
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [INS_W-1:0] r_pc;
    logic [INS_W-1:0] r_ins;
    logic [INS_W-1:0] r_ext;
    logic [INS_W-1:0] r_ins_pc;
    logic [INS_W-1:0] w_pc_upd;
    logic [INS_W-1:0] w_ins_len;
    logic             w_take;
    logic             w_mem_rd;
    logic [INS_W-1:0] w_mem_addr;

    assign w_ins_len = r_ins[EXT_BIT] ? 16'd2 : 16'd1;

    always_comb begin
        w_pc_upd = r_pc;
        if (set_pc)
            w_pc_upd = pc_arg;
        else if (add_pc)
            w_pc_upd = r_ins_pc + pc_arg;
        else if (inc_pc)
            w_pc_upd = r_ins_pc + w_ins_len;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_rd    = 1'b0;
        w_mem_addr  = r_pc;
        w_take      = 1'b0;
        case (r_state)
            FETCH_INS: begin
                if (!halt) begin
                    w_mem_rd    = 1'b1;
                    w_state_nxt = WAIT_INS;
                end
            end
            WAIT_INS:  w_state_nxt = mem_data[EXT_BIT] ? FETCH_EXT : ISSUE;
            FETCH_EXT: begin
                w_mem_rd    = 1'b1;
                w_mem_addr  = r_pc + 16'd1;
                w_state_nxt = WAIT_EXT;
            end
            WAIT_EXT:  w_state_nxt = ISSUE;
            ISSUE: begin
                w_take      = retire;
                w_state_nxt = retire ? FETCH_INS : EXEC;
            end
            EXEC: begin
                w_take = retire;
                if (retire)
                    w_state_nxt = FETCH_INS;
            end
            default:   w_state_nxt = FETCH_INS;
        endcase
        // Reset is synchronous, so the memory strobe must be masked combinationally.
        if (cpu_rst) begin
            w_mem_rd   = 1'b0;
            w_mem_addr = RESET_PC;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state  <= FETCH_INS;
            r_pc     <= RESET_PC;
            r_ins_pc <= RESET_PC;
            r_ins    <= '0;
            r_ext    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == WAIT_INS) begin
                r_ins    <= mem_data;
                r_ins_pc <= r_pc;
                if (!mem_data[EXT_BIT])
                    r_ext <= '0;
            end
            if (r_state == WAIT_EXT)
                r_ext <= mem_data;
            if (w_take)
                r_pc <= w_pc_upd;
        end
    end

    assign mem_rd   = w_mem_rd;
    assign mem_addr = w_mem_addr;
    assign ins      = r_ins;
    assign ext      = r_ext;
    assign ins_pc   = r_ins_pc;
    assign ins_en   = (r_state == ISSUE);

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: directed instructions push expected fetch
// addresses and issued words; a negedge monitor pops and compares.
module tb_fetch;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] ext;
        logic [15:0] pc;
    } issue_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        halt;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] ins;
    logic [15:0] ext;
    logic        ins_en;
    logic [15:0] ins_pc;
    logic        retire;
    logic        set_pc;
    logic        add_pc;
    logic        inc_pc;
    logic [15:0] pc_arg;

    logic [15:0] rom [0:65535];
    logic [15:0] fetch_q [$];
    issue_t      issue_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .halt    (halt),
        .mem_rd  (mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .ins     (ins),
        .ext     (ext),
        .ins_en  (ins_en),
        .ins_pc  (ins_pc),
        .retire  (retire),
        .set_pc  (set_pc),
        .add_pc  (add_pc),
        .inc_pc  (inc_pc),
        .pc_arg  (pc_arg)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk)
        if (mem_rd)
            mem_data <= rom[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every memory read and every issue must match the scoreboard.
    always @(negedge cpu_clk) begin
        if (!cpu_rst) begin
            if (mem_rd) begin
                if (fetch_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got addr %h expected none", mem_addr);
                end else begin
                    chk("fetch_addr", {16'h0, mem_addr}, {16'h0, fetch_q.pop_front()});
                end
            end
            if (ins_en) begin
                if (issue_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ins_en: got ins %h expected none", ins);
                end else begin
                    issue_t e;
                    e = issue_q.pop_front();
                    chk("issue_ins", {16'h0, ins}, {16'h0, e.ins});
                    chk("issue_ext", {16'h0, ext}, {16'h0, e.ext});
                    chk("issue_pc", {16'h0, ins_pc}, {16'h0, e.pc});
                end
            end
        end
    end

    // Called at cycle0 of a fetch (just after the edge entering FETCH_INS).
    // fl = {set, add, inc}; dly = EXEC cycles before retire; hold = raise halt with retire.
    task automatic run_ins(input logic [15:0] pc, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [2:0] fl, input logic [15:0] arg, input int dly,
                           input bit hold);
        int     cyc;
        issue_t e;
        logic   two;
        two = w0[15];
        rom[pc] = w0;
        fetch_q.push_back(pc);
        if (two) begin
            rom[pc + 16'd1] = w1;
            fetch_q.push_back(pc + 16'd1);
        end
        e.ins = w0;
        e.ext = two ? w1 : 16'h0000;
        e.pc  = pc;
        issue_q.push_back(e);
        cyc = 0;
        while (!ins_en && cyc < 20) begin
            @(posedge cpu_clk); #1;
            cyc++;
        end
        chk("issue_latency", cyc, two ? 4 : 2);
        for (int i = 0; i < dly; i++) begin
            @(posedge cpu_clk); #1;
            chk("hold_ins_en", {31'h0, ins_en}, 32'h0);
            chk("hold_ins", {16'h0, ins}, {16'h0, e.ins});
            chk("hold_ext", {16'h0, ext}, {16'h0, e.ext});
            chk("hold_pc", {16'h0, ins_pc}, {16'h0, e.pc});
        end
        retire = 1'b1;
        {set_pc, add_pc, inc_pc} = fl;
        pc_arg = arg;
        if (hold)
            halt = 1'b1;
        @(posedge cpu_clk); #1;
        retire = 1'b0;
        {set_pc, add_pc, inc_pc} = 3'b000;
        pc_arg = 16'h0000;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            rom[i] = 16'h0000;
        cpu_rst = 1'b1;
        halt    = 1'b0;
        retire  = 1'b0;
        set_pc  = 1'b0;
        add_pc  = 1'b0;
        inc_pc  = 1'b0;
        pc_arg  = 16'h0000;
        repeat (3) @(posedge cpu_clk);
        #1;
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_ins", {16'h0, ins}, 32'h0);
        chk("rst_ext", {16'h0, ext}, 32'h0);
        chk("rst_ins_en", {31'h0, ins_en}, 32'h0);
        chk("rst_ins_pc", {16'h0, ins_pc}, 32'h0);
        cpu_rst = 1'b0;

        run_ins(16'h0000, 16'h0123, 16'h0000, 3'b001, 16'h0000, 0, 0); // -> 0001
        run_ins(16'h0001, 16'h0002, 16'h0000, 3'b100, 16'h0004, 0, 0); // -> 0004
        run_ins(16'h0004, 16'h8001, 16'hBEEF, 3'b001, 16'h0000, 0, 0); // -> 0006
        run_ins(16'h0006, 16'h0003, 16'h0000, 3'b100, 16'h0040, 0, 0); // -> 0040
        run_ins(16'h0040, 16'h0004, 16'h0000, 3'b100, 16'h0010, 0, 0); // -> 0010
        run_ins(16'h0010, 16'h0005, 16'h0000, 3'b010, 16'hFFFE, 0, 0); // -> 000E
        run_ins(16'h000E, 16'h0006, 16'h0000, 3'b111, 16'h1234, 0, 0); // set wins -> 1234
        run_ins(16'h1234, 16'h0007, 16'h0000, 3'b010, 16'h0002, 3, 0); // -> 1236
        run_ins(16'h1236, 16'h0008, 16'h0000, 3'b000, 16'h0000, 0, 0); // no flag -> 1236
        run_ins(16'h1236, 16'h0008, 16'h0000, 3'b100, 16'hFFFF, 1, 0); // -> FFFF
        run_ins(16'hFFFF, 16'h8009, 16'h0123, 3'b001, 16'h0000, 0, 1); // ext from 0000 -> 0001

        for (int i = 0; i < 5; i++) begin
            chk("halt_mem_rd", {31'h0, mem_rd}, 32'h0);
            chk("halt_mem_addr", {16'h0, mem_addr}, 32'h0001);
            @(posedge cpu_clk); #1;
        end
        halt = 1'b0;
        run_ins(16'h0001, 16'h0002, 16'h0000, 3'b100, 16'h0004, 0, 0); // -> 0004

        // Abort a 2-word instruction in WAIT_EXT; no issue is queued for it.
        fetch_q.push_back(16'h0004);
        fetch_q.push_back(16'h0005);
        repeat (3) begin
            @(posedge cpu_clk); #1;
        end
        cpu_rst = 1'b1;
        #2;
        chk("midrst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("midrst_mem_addr", {16'h0, mem_addr}, 32'h0);
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        chk("midrst_ins", {16'h0, ins}, 32'h0);
        chk("midrst_ext", {16'h0, ext}, 32'h0);
        chk("midrst_ins_pc", {16'h0, ins_pc}, 32'h0);
        chk("midrst_ins_en", {31'h0, ins_en}, 32'h0);
        run_ins(16'h0000, 16'h0123, 16'h0000, 3'b001, 16'h0000, 0, 0); // -> 0001

        fetch_q.push_back(16'h0001);
        @(negedge cpu_clk); #1;
        chk("fetch_q_empty", fetch_q.size(), 0);
        chk("issue_q_empty", issue_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
